fb_port_arbiter: RTL

//  Shares the single-port 80x60 frame-buffer RAM (13-bit addr, 24-bit pixel) between two requesters.

---
 rtl/fb_port_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the single-port 80x60 frame-buffer RAM between display scanout
// (read-only, high priority) and the processing engine (read/write). One RAM access per cycle.
// An aging counter boosts the processing engine after MAX_WAIT denied cycles.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   disp_req_i/addr_i            display read request
//   disp_gnt_o                   display accepted this cycle (combinational)
//   disp_rvalid_o/rdata_o        display read return
//   proc_req_i/we_i/addr_i/wdata_i  processing-engine request
//   proc_gnt_o                   proc accepted this cycle (combinational)
//   proc_rvalid_o/rdata_o        proc read return (reads only)
//   mem_addr_o/we_o/wdata_o      registered RAM command
//   mem_rdata_i                  RAM read data, RD_LAT cycles after mem_addr_o
//   err_oob_o                    sticky: an out-of-range access was accepted
module fb_port_arbiter #(
    parameter int unsigned AW       = 13,
    parameter int unsigned DW       = 24,
    parameter int unsigned DEPTH    = 4800,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          disp_req_i,
    input  logic [AW-1:0] disp_addr_i,
    output logic          disp_gnt_o,
    output logic          disp_rvalid_o,
    output logic [DW-1:0] disp_rdata_o,
    input  logic          proc_req_i,
    input  logic          proc_we_i,
    input  logic [AW-1:0] proc_addr_i,
    input  logic [DW-1:0] proc_wdata_i,
    output logic          proc_gnt_o,
    output logic          proc_rvalid_o,
    output logic [DW-1:0] proc_rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          err_oob_o
);

    localparam int unsigned WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [0:0] {StNormal, StBoost} mode_e;

    typedef struct packed {
        logic valid;
        logic owner;  // 1 = proc, 0 = display
        logic oob;
    } tag_t;

    mode_e          mode_q, mode_d;
    logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic           mem_we_q, mem_we_d;
    logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
    logic           err_oob_q, err_oob_d;
    tag_t           tag_q [RD_LAT+1];
    tag_t           tag_d;

    logic           disp_acc, proc_acc, sel_oob;
    tag_t           tag_out;

    // Arbitration: proc only wins when boosted or when display is idle.
    always_comb begin
        disp_acc = 1'b0;
        proc_acc = 1'b0;
        if (!rst) begin
            if (proc_req_i && (mode_q == StBoost || !disp_req_i)) begin
                proc_acc = 1'b1;
            end else if (disp_req_i) begin
                disp_acc = 1'b1;
            end
        end
    end

    assign disp_gnt_o = disp_acc;
    assign proc_gnt_o = proc_acc;

    // Aging counter and priority mode.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        mode_d     = mode_q;
        if (proc_acc) begin
            wait_cnt_d = '0;
            mode_d     = StNormal;
        end else begin
            if (proc_req_i && wait_cnt_q != WW'(MAX_WAIT)) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
            if (wait_cnt_d == WW'(MAX_WAIT)) begin
                mode_d = StBoost;
            end
        end
    end

    // Issue stage.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        err_oob_d   = err_oob_q;
        tag_d       = '0;
        sel_oob     = 1'b0;
        if (proc_acc) begin
            sel_oob     = 32'(proc_addr_i) >= DEPTH;
            mem_addr_d  = proc_addr_i;
            mem_we_d    = proc_we_i & ~sel_oob;
            mem_wdata_d = proc_wdata_i;
            tag_d       = '{valid: ~proc_we_i, owner: 1'b1, oob: sel_oob};
        end else if (disp_acc) begin
            sel_oob     = 32'(disp_addr_i) >= DEPTH;
            mem_addr_d  = disp_addr_i;
            mem_wdata_d = '0;
            tag_d       = '{valid: 1'b1, owner: 1'b0, oob: sel_oob};
        end
        if (sel_oob) begin
            err_oob_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= StNormal;
            wait_cnt_q  <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            err_oob_q   <= 1'b0;
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            mode_q      <= mode_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            err_oob_q   <= err_oob_d;
            tag_q[0]    <= tag_d;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_oob_o   = err_oob_q;

    // Return stage: last tag lines up with mem_rdata_i for the access issued RD_LAT cycles ago.
    assign tag_out       = tag_q[RD_LAT];
    assign disp_rvalid_o = tag_out.valid & ~tag_out.owner;
    assign proc_rvalid_o = tag_out.valid & tag_out.owner;
    assign disp_rdata_o  = (disp_rvalid_o && !tag_out.oob) ? mem_rdata_i : '0;
    assign proc_rdata_o  = (proc_rvalid_o && !tag_out.oob) ? mem_rdata_i : '0;

endmodule
